// File: rtl/dram_wrq_pkg.sv
// Shared sizing and types for the DRAM write-data queue.
// DRAM_WRQ_PARITY_EN adds one stored parity bit per lane.
package dram_wrq_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_NUM_LANES = 4;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned MAX_LANES     = 8;

`ifdef DRAM_WRQ_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/dram_wrq_lane_ram.sv
// One lane of the write queue: flop array, synchronous write, asynchronous read.
module dram_wrq_lane_ram #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dram_wrq_buf.sv
// DRAM write-data queue: assembles lane beats into entries, in-order valid/ready pop.
// Optional per-lane parity when DRAM_WRQ_PARITY_EN is defined.
module dram_wrq_buf
    import dram_wrq_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_abort,
    input  logic [NUM_LANES-1:0]        wr_par_inv,
    output logic                        wr_partial,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [NUM_LANES*DATA_W-1:0] rd_data,
    output logic [NUM_LANES-1:0]        rd_par_err,
    output logic                        par_err_sticky,
    output logic [AW:0]                 count,
    output logic                        full
);

    localparam int unsigned LW = DATA_W + PAR_W;

    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count_nxt;
    lane_idx_t     beat, beat_nxt;
    logic          full_nxt;
    logic          sticky_nxt;

    logic wr_acc;
    logic last_beat;
    logic commit;
    logic pop;

    assign wr_ready   = !full;
    assign wr_partial = (beat != '0);
    assign rd_valid   = (count != '0);
    assign wr_acc     = wr_valid && wr_ready && !wr_abort;
    assign last_beat  = (beat == lane_idx_t'(NUM_LANES - 1));
    assign commit     = wr_acc && last_beat;
    assign pop        = rd_valid && rd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat           <= '0;
            full           <= 1'b0;
            par_err_sticky <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count          <= count_nxt;
            beat           <= beat_nxt;
            full           <= full_nxt;
            par_err_sticky <= sticky_nxt;
        end
    end

    // Next-state: abort wins over a same-cycle beat and rewinds assembly to lane 0.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        beat_nxt   = beat;
        sticky_nxt = par_err_sticky;

        if (wr_abort) begin
            beat_nxt = '0;
        end else if (wr_acc) begin
            if (last_beat) begin
                beat_nxt   = '0;
                wr_ptr_nxt = wr_ptr + AW'(1);
            end else begin
                beat_nxt = beat + lane_idx_t'(1);
            end
        end

        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end

        if (commit && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!commit && pop) begin
            count_nxt = count - (AW+1)'(1);
        end

        if (pop && (|rd_par_err)) begin
            sticky_nxt = 1'b1;
        end

        full_nxt = (count_nxt == (AW+1)'(DEPTH));
    end

`ifndef DRAM_WRQ_PARITY_EN
    logic unused_par_inv;
    assign unused_par_inv = ^wr_par_inv;
`endif

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic          lane_we;
        logic [LW-1:0] lane_wdata;
        logic [LW-1:0] lane_rdata;

        assign lane_we = wr_acc && (beat == lane_idx_t'(k));

`ifdef DRAM_WRQ_PARITY_EN
        // Lane k is only written when beat==k, so wr_par_inv[k] is the written lane's bit.
        assign lane_wdata    = {(^wr_data) ^ wr_par_inv[k], wr_data};
        assign rd_par_err[k] = rd_valid && ((^lane_rdata[DATA_W-1:0]) != lane_rdata[DATA_W]);
`else
        assign lane_wdata    = wr_data;
        assign rd_par_err[k] = 1'b0;
`endif

        dram_wrq_lane_ram #(
            .W     (LW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .we    (lane_we),
            .waddr (wr_ptr),
            .wdata (lane_wdata),
            .raddr (rd_ptr),
            .rdata (lane_rdata)
        );

        assign rd_data[k*DATA_W +: DATA_W] = rd_valid ? lane_rdata[DATA_W-1:0] : '0;
    end

endmodule
